// File: rtl/if_fetch.sv
// Instruction fetch: owns the fetch PC and assembles each 32-bit word from four byte reads.
// Latency: first request in T0, if_valid_o in T5 with grant every cycle; +1 cycle per missing grant.
// Backpressure: if_ready_i low holds the presented word; stall_i only gates new memory requests.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  typedef enum logic {FETCH = 1'b0, OUT = 1'b1} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [2:0]  req_cnt;
  logic [2:0]  recv_cnt;
  logic        rd_pend;
  logic [23:0] inst_buf;
  logic        req_ok;
  logic        gnt_ok;

  // Request gating is combinational so a stall or redirect suppresses the request in the same cycle;
  // reset is folded in so the request drops the moment reset asserts.
  always_comb begin
    req_ok = ~rst & (state == FETCH) & (req_cnt < 3'd4) & ~stall_i & ~branch_flag_i;
    gnt_ok = req_ok & mem_gnt_i;
  end

  assign mem_req_o  = req_ok;
  assign mem_addr_o = req_ok ? (fetch_pc + {29'd0, req_cnt}) : 32'd0;

  // Fetch FSM: issue byte requests, capture returning bytes little-endian, present, then advance PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      req_cnt    <= 3'd0;
      recv_cnt   <= 3'd0;
      rd_pend    <= 1'b0;
      inst_buf   <= 24'd0;
      if_valid_o <= 1'b0;
      if_pc_o    <= 32'd0;
      if_inst_o  <= 32'd0;
    end else if (branch_flag_i) begin
      // Redirect wins over everything, including a same-cycle handshake; any in-flight byte is dropped.
      state      <= FETCH;
      fetch_pc   <= branch_target_i & ~32'h3;
      req_cnt    <= 3'd0;
      recv_cnt   <= 3'd0;
      rd_pend    <= 1'b0;
      if_valid_o <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          rd_pend <= gnt_ok;
          if (gnt_ok) begin
            req_cnt <= req_cnt + 3'd1;
          end
          if (rd_pend) begin
            recv_cnt <= recv_cnt + 3'd1;
            case (recv_cnt)
              3'd0: inst_buf[7:0]   <= mem_data_i;
              3'd1: inst_buf[15:8]  <= mem_data_i;
              3'd2: inst_buf[23:16] <= mem_data_i;
              3'd3: begin
                if_inst_o  <= {mem_data_i, inst_buf};
                if_pc_o    <= fetch_pc;
                if_valid_o <= 1'b1;
                state      <= OUT;
              end
              default: ;
            endcase
          end
        end
        OUT: begin
          rd_pend <= 1'b0;
          if (if_ready_i) begin
            fetch_pc   <= fetch_pc + 32'd4;
            req_cnt    <= 3'd0;
            recv_cnt   <= 3'd0;
            if_valid_o <= 1'b0;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: byte-memory model, scoreboard of expected {pc, inst}, table of grant/stall patterns.
// A second instance with RESET_PC = 32'hFFFFFFFC covers the PC wrap after the first accept.
// Inputs are driven at the falling edge and outputs sampled 1 time unit later.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_gnt;
  logic        if_ready;
  logic        mem_req, w_mem_req;
  logic [31:0] mem_addr, w_mem_addr;
  logic [7:0]  mem_data, w_mem_data;
  logic        if_valid, w_valid;
  logic [31:0] if_pc, w_pc, if_inst, w_inst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch_flag),
    .branch_target_i(branch_target), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_gnt_i(mem_gnt), .mem_data_i(mem_data), .if_valid_o(if_valid),
    .if_ready_i(if_ready), .if_pc_o(if_pc), .if_inst_o(if_inst)
  );

  if_fetch #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(1'b0),
    .branch_target_i(32'd0), .mem_req_o(w_mem_req), .mem_addr_o(w_mem_addr),
    .mem_gnt_i(mem_gnt), .mem_data_i(w_mem_data), .if_valid_o(w_valid),
    .if_ready_i(if_ready), .if_pc_o(w_pc), .if_inst_o(w_inst)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  // Memory model: a granted byte read returns its data in the following cycle.
  logic        gq, wq;
  logic [31:0] gaddr, waddr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gq <= 1'b0; wq <= 1'b0; gaddr <= 32'd0; waddr <= 32'd0;
    end else begin
      gq <= mem_req && mem_gnt;     gaddr <= mem_addr;
      wq <= w_mem_req && mem_gnt;   waddr <= w_mem_addr;
    end
  end
  assign mem_data   = gq ? mem_byte(gaddr) : 8'hEE;
  assign w_mem_data = wq ? mem_byte(waddr) : 8'hEE;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.inst = exp_inst(pc);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: output with empty scoreboard, got pc %h", name, if_pc);
    end else begin
      e = sb.pop_front();
      chk({name, "_pc"}, if_pc, e.pc);
      chk({name, "_inst"}, if_inst, e.inst);
    end
  endtask

  task automatic start_fetch(input logic [31:0] target);
    @(negedge clk);
    branch_flag = 1'b1; branch_target = target; if_ready = 1'b0; stall = 1'b0; mem_gnt = 1'b1;
    #1 chk("branch_req_gated", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      branch_flag = 1'b0;
      #1;
      if (if_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] target;
    logic [15:0] gnt;
    logic [15:0] stl;
    int          lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int          lat;
    int          grants;
    logic        exp_req;
    logic        g, s;
    logic [31:0] base;
    logic [31:0] held_pc, held_inst;
    bit          done;

    vt[0] = '{32'h00000200, 16'hFFFF, 16'h0000, 5};
    vt[1] = '{32'h00000300, 16'hAAAA, 16'h0000, 9};
    vt[2] = '{32'h00000401, 16'hFFFE, 16'h0000, 6};
    vt[3] = '{32'h00000502, 16'hFFF7, 16'h0000, 6};
    vt[4] = '{32'h00000600, 16'hFFFF, 16'h0002, 6};
    vt[5] = '{32'hFFFFFFFF, 16'hFFFF, 16'h0018, 7};
    vt[6] = '{32'h12345677, 16'h5555, 16'h0000, 8};

    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'd0;
    mem_gnt = 1'b1; if_ready = 1'b0;

    // Reset state, with requests otherwise enabled.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_wrap_req", {31'd0, w_mem_req}, 32'd0);

    // Basic fetch from reset, plus the wrap instance running alongside.
    @(negedge clk);
    rst = 1'b0;
    push_exp(32'd0);
    #1;
    chk("basic_addr_t0", mem_addr, 32'd0);
    chk("basic_req_t0", {31'd0, mem_req}, 32'd1);
    chk("wrap_addr_t0", w_mem_addr, 32'hFFFFFFFC);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      if (k <= 3) chk($sformatf("basic_addr_t%0d", k), mem_addr, k);
      if (k == 4) chk("basic_req_t4", {31'd0, mem_req}, 32'd0);
      if (k < 5) chk($sformatf("basic_novalid_t%0d", k), {31'd0, if_valid}, 32'd0);
    end
    chk("basic_valid_t5", {31'd0, if_valid}, 32'd1);
    chk("basic_inst_const", if_inst, 32'h00100513);
    pop_check("basic");
    chk("wrap_valid_t5", {31'd0, w_valid}, 32'd1);
    chk("wrap_pc", w_pc, 32'hFFFFFFFC);
    chk("wrap_inst", w_inst, exp_inst(32'hFFFFFFFC));
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;
    #1;
    chk("basic_next_req_t6", {31'd0, mem_req}, 32'd1);
    chk("basic_next_addr_t6", mem_addr, 32'd4);
    chk("wrap_next_addr_t6", w_mem_addr, 32'd0);

    // Table of grant/stall patterns, each entered by a redirect (dropping whatever was in flight).
    for (int v = 0; v < 7; v++) begin
      start_fetch(vt[v].target);
      base = vt[v].target & ~32'h3;
      push_exp(base);
      grants = 0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
        @(negedge clk);
        branch_flag = 1'b0;
        if_ready = 1'b0;
        g = (k < 16) ? vt[v].gnt[k[3:0]] : 1'b1;
        s = (k < 16) ? vt[v].stl[k[3:0]] : 1'b0;
        mem_gnt = g;
        stall = s;
        #1;
        exp_req = (grants < 4) && !s;
        chk($sformatf("v%0d_req_k%0d", v, k), {31'd0, mem_req}, {31'd0, exp_req});
        chk($sformatf("v%0d_addr_k%0d", v, k), mem_addr, exp_req ? base + grants : 32'd0);
        if (exp_req && g) grants++;
        if (if_valid) begin
          chk($sformatf("v%0d_latency", v), k, vt[v].lat);
          pop_check($sformatf("v%0d", v));
          if_ready = 1'b1;
          done = 1'b1;
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL v%0d_timeout: no if_valid within 40 cycles, required latency %0d", v, vt[v].lat);
      end
    end
    @(negedge clk);
    if_ready = 1'b0; stall = 1'b0; mem_gnt = 1'b1;

    // Backpressure with stall toggling: presented word must hold, no requests.
    start_fetch(32'h00000700);
    push_exp(32'h00000700);
    wait_valid(lat);
    chk("bp_latency", lat, 5);
    held_pc = 32'h00000700;
    held_inst = exp_inst(32'h00000700);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      stall = k[0];
      #1;
      chk($sformatf("bp_valid_%0d", k), {31'd0, if_valid}, 32'd1);
      chk($sformatf("bp_pc_%0d", k), if_pc, held_pc);
      chk($sformatf("bp_inst_%0d", k), if_inst, held_inst);
      chk($sformatf("bp_req_%0d", k), {31'd0, mem_req}, 32'd0);
    end
    stall = 1'b1;
    if_ready = 1'b1;
    pop_check("bp");
    @(negedge clk);
    if_ready = 1'b0;
    stall = 1'b0;

    // Branch mid-fetch after two granted bytes; the in-flight byte is discarded.
    start_fetch(32'h00000800);
    @(negedge clk); branch_flag = 1'b0;
    #1 chk("mid_addr0", mem_addr, 32'h00000800);
    @(negedge clk);
    #1 chk("mid_addr1", mem_addr, 32'h00000801);
    @(negedge clk);
    branch_flag = 1'b1; branch_target = 32'h00000103;
    #1 chk("mid_br_req", {31'd0, mem_req}, 32'd0);
    push_exp(32'h00000100);
    @(negedge clk);
    branch_flag = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      #1 chk($sformatf("mid_new_addr%0d", j), mem_addr, 32'h00000100 + j);
    end
    wait_valid(lat);
    chk("mid_latency", lat, 1);
    pop_check("mid");
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;

    // Branch coinciding with the handshake: transfer is void, fetch restarts at the target.
    start_fetch(32'h00000020);
    push_exp(32'h00000020);
    wait_valid(lat);
    chk("bh_latency", lat, 5);
    pop_check("bh_first");
    if_ready = 1'b1; branch_flag = 1'b1; branch_target = 32'h00000040;
    @(negedge clk);
    if_ready = 1'b0; branch_flag = 1'b0;
    #1;
    chk("bh_valid_cleared", {31'd0, if_valid}, 32'd0);
    chk("bh_addr", mem_addr, 32'h00000040);
    push_exp(32'h00000040);
    wait_valid(lat);
    chk("bh_latency2", lat, 4);
    pop_check("bh_second");
    if_ready = 1'b1;
    @(negedge clk);
    if_ready = 1'b0;

    // Asynchronous reset mid-fetch, between clock edges.
    #1 chk("ar_pre_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", {31'd0, mem_req}, 32'd0);
    chk("ar_addr", mem_addr, 32'd0);
    chk("ar_valid", {31'd0, if_valid}, 32'd0);
    chk("ar_pc", if_pc, 32'd0);
    chk("ar_inst", if_inst, 32'd0);
    chk("ar_wrap_pc", w_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ar_restart_addr", mem_addr, 32'd0);
    chk("ar_restart_req", {31'd0, mem_req}, 32'd1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of if_id and replaces the bare pc_reg/rom_addr path.
- Owns the fetch PC and reads each 32-bit instruction as four sequential byte reads over an 8-bit memory port, behind a request/grant arbiter.
- Assembles the bytes little-endian and presents {pc, inst} to if_id with a valid/ready handshake.
- Accepts branch redirects and pipeline stalls from the control path.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; 1'b1 = RstEnable.
- stall_i  input  1  hold request from control; suppresses new memory requests.
- branch_flag_i  input  1  redirect fetch this cycle.
- branch_target_i  input  32  redirect address; bits [1:0] are ignored and forced to 00.
- mem_req_o  output  1  byte read request to the memory arbiter.
- mem_addr_o  output  32  byte address of the request.
- mem_gnt_i  input  1  arbiter accepts mem_req_o this cycle.
- mem_data_i  input  8  read data; valid exactly one cycle after a granted request.
- if_valid_o  output  1  if_pc_o/if_inst_o hold a complete instruction.
- if_ready_i  input  1  if_id accepts the instruction this cycle.
- if_pc_o  output  32  address of the presented instruction.
- if_inst_o  output  32  presented instruction.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - mem_req_o=0, mem_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
  - fetch_pc=RESET_PC, req_cnt=0, recv_cnt=0, rd_pend=0, state=FETCH.
- States: FETCH, OUT.
- FETCH:
  - mem_req_o = (req_cnt<4) & ~stall_i & ~branch_flag_i.
  - mem_addr_o = fetch_pc + req_cnt, 32-bit modulo; drive 0 when mem_req_o=0.
  - mem_req_o & mem_gnt_i → req_cnt++ and rd_pend=1 for the next cycle.
  - When rd_pend=1: byte lane recv_cnt of the instruction buffer ← mem_data_i (byte0 → bits[7:0], ... byte3 → bits[31:24]); recv_cnt++.
  - Completion: the cycle recv_cnt becomes 4 → next state OUT. In OUT, if_valid_o=1, if_pc_o=fetch_pc, if_inst_o=assembled word.
- Latency and throughput:
  - With grant every cycle and no stall, the first request is in cycle T0 and if_valid_o rises in T5.
  - Throughput is one instruction per 6 cycles.
  - Each missing grant adds one cycle.
- OUT:
  - mem_req_o=0.
  - Outputs are held stable while if_ready_i=0, including while stall_i=1.
  - if_valid_o & if_ready_i & ~branch_flag_i → fetch_pc += 4 (wraps 32'hFFFFFFFC → 0); if_valid_o=0; counters cleared; state FETCH.
  - Handshake ignores stall_i. Stall only gates memory requests.
- Stall (FETCH):
  - No new request is issued.
  - An already-granted byte is still captured on the following cycle.
  - req_cnt, recv_cnt and fetch_pc are frozen otherwise.
- Branch (any state, highest priority):
  - mem_req_o is forced 0 in the same cycle.
  - Next cycle: fetch_pc=branch_target_i&~3, req_cnt=recv_cnt=0, if_valid_o=0, state FETCH.
  - rd_pend is cleared, so the byte returned for a request granted in the branch cycle's predecessor is discarded.
  - If branch_flag_i coincides with if_valid_o & if_ready_i, the transfer is void: fetch_pc is not incremented, and if_id flushes on the same branch signal.
  - Branch while stalled: redirect still takes effect; requests resume when stall_i falls.
- Boundaries:
  - req_cnt saturates at 4; recv_cnt never exceeds req_cnt.
  - mem_gnt_i while mem_req_o=0 is ignored.
  - Byte addresses fetch_pc+1..+3 wrap modulo 2^32.

Test Plan:
- Basic fetch: rst pulse, mem_gnt_i=1, memory bytes 0x00..0x03 = 13 05 10 00 → mem_addr_o 0,1,2,3 on cycles T0..T3; if_valid_o=1 at T5 with if_pc_o=0, if_inst_o=32'h00100513. With if_ready_i=1, next request has addr 4 at T6.
- Grant gaps: mem_gnt_i low on alternate cycles → same if_inst_o, valid at T9. mem_addr_o holds until granted.
- Backpressure and stall: if_ready_i=0 for 5 cycles with stall_i toggling → if_valid_o, if_pc_o and if_inst_o unchanged; mem_req_o=0 throughout.
- Branch mid-fetch: branch_flag_i with target 32'h00000103 after 2 bytes granted → next requests at 0x100..0x103. The in-flight byte is dropped; the instruction is assembled only from the new bytes.
- Branch with handshake: branch_flag_i in the same cycle as valid&ready at pc 0x20, target 0x40 → next fetch starts at 0x40, not 0x24.
- Wrap and async reset: RESET_PC=32'hFFFFFFFC, then accept → next fetch at 0. Assert rst asynchronously mid-FETCH → all outputs 0 before the next clock edge.
